set_scan_ctrl: RTL and testbench
================================

Name: set_scan_ctrl

Overview:
- Sequencer and accumulator around the distance PE.
- Latches one job of three circles (A, B, C) plus a set-operation mode, then sweeps every lattice point of the 8x8 grid through the PE.
- Consumes the PE's 3-bit coverage vector, applies the mode's set function and counts qualifying points.
- Returns the count with a one-cycle valid pulse.

Parameters:
- GRID_MIN, 1, lowest x/y coordinate swept.
- GRID_MAX, 8, highest x/y coordinate swept.
- CNT_W, 8, width of the candidate counter; must hold (GRID_MAX-GRID_MIN+1)^2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  job start strobe; sampled only in IDLE.
- central  input  `CENTRAL_SZ  {A_X,A_Y,B_X,B_Y,C_X,C_Y}, 4 bits each.
- radius  input  `RADIUS_SZ  {A_R,B_R,C_R}, 4 bits each.
- mode  input  2  set function select.
- coord_o  output  `COORD_SZ  current point to PE, {X,Y}.
- cent_buf_o  output  `CENTRAL_SZ  latched centres to PE.
- r_buf_o  output  `RADIUS_SZ  latched radii to PE.
- covered_i  input  `COVERED_SZ  PE result: [2]=A, [1]=B, [0]=C.
- busy  output  1  job in progress.
- valid  output  1  one-cycle pulse; candidate is meaningful.
- candidate  output  CNT_W  number of qualifying points.

Behaviour:
- Reset: state=IDLE; busy=0, valid=0, candidate=0; coord_o={GRID_MIN,GRID_MIN}; cent_buf_o=0, r_buf_o=0; counter=0. Reset during any state aborts the job immediately; no valid is issued.
- States:
  - IDLE: on en=1, latch central, radius and mode, clear the counter, go to SCAN with coord=(GRID_MIN,GRID_MIN).
  - SCAN: one point per cycle. X is the inner loop and Y the outer loop: (1,1),(2,1)..(8,1),(1,2)..(8,8). Each cycle, if f(mode, covered_i)=1 the counter increments. After (8,8) go to DONE.
  - DONE: valid=1 for exactly one cycle; candidate=counter; return to IDLE.
- busy=1 in SCAN and DONE-wait states; busy=0 in the cycle valid=1.
- Latency: en sampled at edge T; SCAN occupies T+1..T+64; valid is high in cycle T+65.
- en while busy is ignored; the latched job operands do not change mid-job.
- en is accepted again from the first IDLE cycle after valid.
- candidate holds its value after valid until the next job's valid; it is only updated in DONE.
- Set function f, with a=covered_i[2], b=covered_i[1], c=covered_i[0]:
  - mode 0: a
  - mode 1: a&b
  - mode 2: a^b
  - mode 3: exactly two of {a,b,c} set, i.e. (a&b&~c)|(a&~b&c)|(~a&b&c)
- Counter saturates at 2^CNT_W-1; with defaults the maximum of 64 never saturates.
- Coordinate counters wrap only via state exit; there is no wrap inside SCAN.
- A point on the circle boundary is covered; that decision is made by the PE and is not re-evaluated here.

Optional Feature:
- Macro: SET_SCAN_PIPE_EN.
- Defined: covered_i and the point-valid flag are registered for one stage before the set function and counter. A drain cycle follows the final point, so valid moves to T+66. busy stays high through the drain cycle.
- Undefined: covered_i is consumed combinationally in the same cycle coord_o is driven; valid at T+65.

Decomposition:
- Shared def package: `COORD_SZ, `RADIUS_SZ, `CENTRAL_SZ, `COVERED_SZ, field selects `X_COORD/`Y_COORD, `A_X..`C_Y, `A_R..`C_R.
- Add mode encodings `MODE_A=0, `MODE_AND=1, `MODE_XOR=2, `MODE_TWO=3, and state encodings.
- One natural sub-module: set_func, a combinational mode/covered-to-hit decoder. The counter and FSM stay in the top module.
- The PE is instantiated by the parent, not inside this block.

Test Plan:
- A=(4,4), r=2; B,C far with r=0; mode 0, en at T -> busy T+1..T+64, valid at T+65, candidate=13.
- A=B=(4,4), r=2; mode 1 -> 13; mode 2 -> 0; A=B=C, mode 3 -> 0.
- A=(1,1), r=15; mode 0 -> candidate=64. A=(5,5), r=0 -> candidate=1 (centre only).
- en pulsed again at T+10 with different operands -> ignored; result equals first job; next en after valid is accepted.
- rst asserted at T+30 mid-scan -> busy=0, valid=0, candidate=0, coord_o=(1,1) immediately; a new job runs cleanly afterwards.
- With SET_SCAN_PIPE_EN: repeat the first case -> valid at T+66, candidate=13.

Source files
------------

// File: rtl/set_scan_ctrl_pkg.sv
// ============================================================================
// Module : set_scan_ctrl_pkg
// Brief  : Shared widths, field positions, mode and state encodings.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package set_scan_ctrl_pkg;

  localparam int COORD_W    = 4;
  localparam int COORD_SZ   = 2 * COORD_W;
  localparam int RADIUS_SZ  = 3 * COORD_W;
  localparam int CENTRAL_SZ = 6 * COORD_W;
  localparam int COVERED_SZ = 3;

  // LSB positions of the 4-bit fields inside the packed buses
  localparam int X_COORD = 4;
  localparam int Y_COORD = 0;
  localparam int A_X = 20;
  localparam int A_Y = 16;
  localparam int B_X = 12;
  localparam int B_Y = 8;
  localparam int C_X = 4;
  localparam int C_Y = 0;
  localparam int A_R = 8;
  localparam int B_R = 4;
  localparam int C_R = 0;

  typedef enum logic [1:0] {
    MODE_A   = 2'd0,
    MODE_AND = 2'd1,
    MODE_XOR = 2'd2,
    MODE_TWO = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/set_scan_ctrl_if.sv
// ============================================================================
// Module : set_scan_ctrl_if
// Brief  : Job request/result and PE bus of the scan controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface set_scan_ctrl_if #(
  parameter int CNT_W = 8
);
  import set_scan_ctrl_pkg::*;

  logic                  en;
  logic [CENTRAL_SZ-1:0] central;
  logic [RADIUS_SZ-1:0]  radius;
  logic [1:0]            mode;
  logic [COORD_SZ-1:0]   coord_o;
  logic [CENTRAL_SZ-1:0] cent_buf_o;
  logic [RADIUS_SZ-1:0]  r_buf_o;
  logic [COVERED_SZ-1:0] covered_i;
  logic                  busy;
  logic                  valid;
  logic [CNT_W-1:0]      candidate;

  modport slave (
    input  en, central, radius, mode, covered_i,
    output coord_o, cent_buf_o, r_buf_o, busy, valid, candidate
  );

  modport master (
    output en, central, radius, mode, covered_i,
    input  coord_o, cent_buf_o, r_buf_o, busy, valid, candidate
  );

endinterface

`default_nettype wire

// File: rtl/set_scan_ctrl_set_func.sv
// ============================================================================
// Module : set_scan_ctrl_set_func
// Brief  : Combinational decoder from coverage vector and mode to a hit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module set_scan_ctrl_set_func
  import set_scan_ctrl_pkg::*;
(
  input  mode_t                 mode,
  input  logic [COVERED_SZ-1:0] covered,
  output logic                  hit
);

  logic w_a, w_b, w_c;

  assign w_a = covered[2];
  assign w_b = covered[1];
  assign w_c = covered[0];

  always_comb begin
    hit = 1'b0;
    case (mode)
      MODE_A:   hit = w_a;
      MODE_AND: hit = w_a & w_b;
      MODE_XOR: hit = w_a ^ w_b;
      MODE_TWO: hit = (w_a & w_b & ~w_c) | (w_a & ~w_b & w_c) | (~w_a & w_b & w_c);
      default:  hit = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/set_scan_ctrl.sv
// ============================================================================
// Module : set_scan_ctrl
// Brief  : Sweeps the lattice through the distance PE and counts hits.
//          SET_SCAN_PIPE_EN adds a register stage on the PE result.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module set_scan_ctrl
  import set_scan_ctrl_pkg::*;
#(
  parameter int GRID_MIN = 1,
  parameter int GRID_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  set_scan_ctrl_if.slave bus
);

  localparam logic [COORD_W-1:0] c_grid_min = COORD_W'(GRID_MIN);
  localparam logic [COORD_W-1:0] c_grid_max = COORD_W'(GRID_MAX);

  state_t                r_state;
  mode_t                 r_mode;
  logic [COORD_W-1:0]    r_x;
  logic [COORD_W-1:0]    r_y;
  logic [CENTRAL_SZ-1:0] r_cent;
  logic [RADIUS_SZ-1:0]  r_rad;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_cand;
  logic                  r_busy;
  logic                  r_valid;

  logic                  w_last;
  logic                  w_pt_valid;
  logic                  w_hit;
  logic [COVERED_SZ-1:0] w_cov;
  logic [CNT_W-1:0]      w_cnt_next;

  assign w_last = (r_x == c_grid_max) && (r_y == c_grid_max);

`ifdef SET_SCAN_PIPE_EN
  logic [COVERED_SZ-1:0] r_cov;
  logic                  r_pt_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cov      <= '0;
      r_pt_valid <= 1'b0;
    end else begin
      r_cov      <= bus.covered_i;
      r_pt_valid <= (r_state == ST_SCAN);
    end
  end

  assign w_cov      = r_cov;
  assign w_pt_valid = r_pt_valid;
`else
  assign w_cov      = bus.covered_i;
  assign w_pt_valid = (r_state == ST_SCAN);
`endif

  set_scan_ctrl_set_func u_set_func (
    .mode    (r_mode),
    .covered (w_cov),
    .hit     (w_hit)
  );

  // Saturating increment; the all-ones value is sticky
  assign w_cnt_next = (w_pt_valid && w_hit && (r_cnt != {CNT_W{1'b1}})) ?
                      r_cnt + 1'b1 : r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_A;
      r_x     <= c_grid_min;
      r_y     <= c_grid_min;
      r_cent  <= '0;
      r_rad   <= '0;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.en) begin
            r_cent  <= bus.central;
            r_rad   <= bus.radius;
            r_mode  <= mode_t'(bus.mode);
            r_cnt   <= '0;
            r_x     <= c_grid_min;
            r_y     <= c_grid_min;
            r_busy  <= 1'b1;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_cnt <= w_cnt_next;
          if (w_last) begin
            r_x <= c_grid_min;
            r_y <= c_grid_min;
`ifdef SET_SCAN_PIPE_EN
            r_state <= ST_DRAIN;
`else
            r_cand  <= w_cnt_next;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
`endif
          end else if (r_x == c_grid_max) begin
            r_x <= c_grid_min;
            r_y <= r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
        ST_DRAIN: begin
          r_cnt   <= w_cnt_next;
          r_cand  <= w_cnt_next;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.coord_o    = {r_x, r_y};
  assign bus.cent_buf_o = r_cent;
  assign bus.r_buf_o    = r_rad;
  assign bus.busy       = r_busy;
  assign bus.valid      = r_valid;
  assign bus.candidate  = r_cand;

endmodule

`default_nettype wire

// File: tb/tb_set_scan_ctrl.sv
// ============================================================================
// Module : tb_set_scan_ctrl
// Brief  : Randomised self-checking bench with a grid-level reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_set_scan_ctrl;
  import set_scan_ctrl_pkg::*;

`ifdef SET_SCAN_PIPE_EN
  localparam int VL = 65;
`else
  localparam int VL = 64;
`endif

  logic clk;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  set_scan_ctrl_if #(.CNT_W(8)) bus ();

  set_scan_ctrl #(
    .GRID_MIN (1),
    .GRID_MAX (8),
    .CNT_W    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit in_circle(logic [7:0] pt, logic [7:0] cen, logic [3:0] r);
    int dx, dy;
    dx = int'(pt[7:4]) - int'(cen[7:4]);
    dy = int'(pt[3:0]) - int'(cen[3:0]);
    return (dx * dx + dy * dy) <= (int'(r) * int'(r));
  endfunction

  // Distance PE stand-in
  always_comb begin
    bus.covered_i = {in_circle(bus.coord_o, bus.cent_buf_o[A_Y+:8], bus.r_buf_o[A_R+:4]),
                     in_circle(bus.coord_o, bus.cent_buf_o[B_Y+:8], bus.r_buf_o[B_R+:4]),
                     in_circle(bus.coord_o, bus.cent_buf_o[C_Y+:8], bus.r_buf_o[C_R+:4])};
  end

  function automatic int ref_count(logic [23:0] c, logic [11:0] r, logic [1:0] m);
    int cnt, a, b, cc, hit;
    logic [7:0] pt;
    cnt = 0;
    for (int y = 1; y <= 8; y++) begin
      for (int x = 1; x <= 8; x++) begin
        pt  = {4'(x), 4'(y)};
        a   = int'(in_circle(pt, c[23:16], r[11:8]));
        b   = int'(in_circle(pt, c[15:8], r[7:4]));
        cc  = int'(in_circle(pt, c[7:0], r[3:0]));
        case (m)
          2'd0:    hit = a;
          2'd1:    hit = a & b;
          2'd2:    hit = (a != b) ? 1 : 0;
          default: hit = ((a + b + cc) == 2) ? 1 : 0;
        endcase
        cnt += hit;
      end
    end
    return (cnt > 255) ? 255 : cnt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Reference model: m_k counts edges since the accepting edge, -1 when idle
  int          m_k    = -1;
  int          m_res  = 0;
  logic [23:0] m_cent = '0;
  logic [11:0] m_rad  = '0;
  logic [7:0]  m_cand = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k    = -1;
      m_cent = '0;
      m_rad  = '0;
      m_cand = '0;
    end else if (m_k < 0) begin
      if (bus.en === 1'b1) begin
        m_k    = 0;
        m_cent = bus.central;
        m_rad  = bus.radius;
        m_res  = ref_count(bus.central, bus.radius, bus.mode);
      end
    end else begin
      m_k++;
      if (m_k == VL) m_cand = 8'(m_res);
      if (m_k > VL) m_k = -1;
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_coord;
    exp_coord = (m_k >= 0 && m_k < 64) ? {4'(1 + m_k % 8), 4'(1 + m_k / 8)} : 8'h11;
    chk("busy", 32'(bus.busy), 32'(m_k >= 0 && m_k < VL));
    chk("valid", 32'(bus.valid), 32'(m_k == VL));
    chk("candidate", 32'(bus.candidate), 32'(m_cand));
    chk("coord", 32'(bus.coord_o), 32'(exp_coord));
    chk("cent_buf", 32'(bus.cent_buf_o), 32'(m_cent));
    chk("r_buf", 32'(bus.r_buf_o), 32'(m_rad));
  end

  task automatic start_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    bus.central = c;
    bus.radius  = r;
    bus.mode    = m;
    bus.en      = 1'b1;
    @(negedge clk);
    bus.en      = 1'b0;
    bus.central = 24'($urandom);
    bus.radius  = 12'($urandom);
    bus.mode    = 2'($urandom);
  endtask

  task automatic wait_done(input string name, input int lit, input int n0);
    int n;
    n = n0;
    while (bus.valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(VL));
    if (lit >= 0) chk({name, "_cand"}, 32'(bus.candidate), 32'(lit));
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_valid"}, 32'(bus.valid), 32'd0);
    chk({name, "_cand"}, 32'(bus.candidate), 32'd0);
    chk({name, "_coord"}, 32'(bus.coord_o), 32'h11);
    chk({name, "_cent"}, 32'(bus.cent_buf_o), 32'd0);
    chk({name, "_rbuf"}, 32'(bus.r_buf_o), 32'd0);
  endtask

  localparam logic [23:0] CEN_A44   = {4'd4, 4'd4, 4'd15, 4'd15, 4'd15, 4'd15};
  localparam logic [23:0] CEN_AB44  = {4'd4, 4'd4, 4'd4, 4'd4, 4'd15, 4'd15};
  localparam logic [23:0] CEN_ABC44 = {4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
  localparam logic [23:0] CEN_A11   = {4'd1, 4'd1, 4'd15, 4'd15, 4'd15, 4'd15};
  localparam logic [23:0] CEN_A55   = {4'd5, 4'd5, 4'd15, 4'd15, 4'd15, 4'd15};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.central = '0;
    bus.radius  = '0;
    bus.mode    = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    start_job(CEN_A44, {4'd2, 4'd0, 4'd0}, 2'd0);
    wait_done("a_r2", 13, 0);
    start_job(CEN_AB44, {4'd2, 4'd2, 4'd0}, 2'd1);
    wait_done("and", 13, 0);
    start_job(CEN_AB44, {4'd2, 4'd2, 4'd0}, 2'd2);
    wait_done("xor", 0, 0);
    start_job(CEN_ABC44, {4'd2, 4'd2, 4'd2}, 2'd3);
    wait_done("two", 0, 0);
    start_job(CEN_A11, {4'd15, 4'd0, 4'd0}, 2'd0);
    wait_done("full", 64, 0);
    start_job(CEN_A55, {4'd0, 4'd0, 4'd0}, 2'd0);
    wait_done("centre", 1, 0);

    // A second en mid-job must not disturb the running job
    start_job(CEN_A44, {4'd2, 4'd0, 4'd0}, 2'd0);
    repeat (9) @(negedge clk);
    bus.central = CEN_A11;
    bus.radius  = {4'd15, 4'd0, 4'd0};
    bus.mode    = 2'd0;
    bus.en      = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    wait_done("en_ignored", 13, 10);

    // Reset in the middle of a scan
    start_job(CEN_A11, {4'd15, 4'd0, 4'd0}, 2'd0);
    repeat (28) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_job(CEN_A44, {4'd2, 4'd0, 4'd0}, 2'd0);
    wait_done("after_rst", 13, 0);

    for (int j = 0; j < 20; j++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_job(24'($urandom), 12'($urandom), 2'($urandom_range(0, 3)));
      wait_done("rnd", -1, 0);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
